led_cursor_ctrl: RTL and testbench

- Controller that sequences a one-hot 16-LED cursor on the board from three push-buttons (left, right, mode) plus an internal auto-sweep timer.
- Debounces and edge-detects the raw buttons, then arbitrates between manual move requests and sweep ticks.
- Owns the cursor position register and drives `led` directly.
- Top-level block between the board button pins and the LED bank.

---
 rtl/led_cursor_pkg.sv | 18 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/led_cursor_ctrl.sv | 89 ++++++++
 tb/tb_led_cursor_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/led_cursor_pkg.sv
// led_cursor_pkg: shared FSM states, widths and helpers for the LED cursor controller
package led_cursor_pkg;

   localparam int LED_W = 16;
   localparam int POS_W = 4;
   localparam logic [POS_W-1:0] POS_MAX = 4'd15;

   typedef enum logic [1:0] {
      MANUAL      = 2'd0,
      SWEEP_LEFT  = 2'd1,
      SWEEP_RIGHT = 2'd2
   } state_t;

   function automatic logic [LED_W-1:0] pos_to_led(input logic [POS_W-1:0] p);
      return {{(LED_W-1){1'b0}}, 1'b1} << p;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button, accepts a level after a stable run, pulses on press
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          btn_s;
   logic          level_q;
   logic [CW-1:0] cnt;

   // two-flop synchroniser for the asynchronous button pin
   always_ff @(posedge clk or posedge rst)
      if (rst) {sync1, btn_s} <= 2'b00;
      else     {sync1, btn_s} <= {raw, sync1};

   // count consecutive disagreeing samples; adopt the new level once the run is long enough
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         level <= 1'b0;
         cnt   <= '0;
      end else if (btn_s != level) begin
         if (cnt == CNT_LAST) begin
            level <= btn_s;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end

   // delayed level for rising-edge detection
   always_ff @(posedge clk or posedge rst)
      if (rst) level_q <= 1'b0;
      else     level_q <= level;

   assign press = level & ~level_q;

endmodule

// File: rtl/led_cursor_ctrl.sv
// led_cursor_ctrl: one-hot 16-LED cursor driven by debounced buttons and an auto-sweep timer
module led_cursor_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SWEEP_DIV       = 10_000_000,
   parameter int START_POS       = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btnL,
   input  logic        btnR,
   input  logic        btnU,
   output logic [15:0] led,
   output logic [3:0]  pos,
   output logic        sweep_active
);

   import led_cursor_pkg::*;

   localparam int SW = $clog2(SWEEP_DIV);
   localparam logic [SW-1:0] SW_LAST = SW'(SWEEP_DIV - 1);

   logic [2:0]       raw_btn;
   logic [2:0]       press;
   logic             press_l;
   logic             press_r;
   logic             press_u;
   logic             tick;
   state_t           state;
   state_t           state_n;
   logic [POS_W-1:0] pos_n;
   logic [SW-1:0]    cnt;
   logic [SW-1:0]    cnt_n;

   assign raw_btn = {btnU, btnR, btnL};

   for (genvar i = 0; i < 3; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_btn[i]),
         .level (),
         .press (press[i])
      );
   end

   assign press_l      = press[0];
   assign press_r      = press[1];
   assign press_u      = press[2];
   assign sweep_active = (state != MANUAL);
   assign tick         = sweep_active && (cnt == SW_LAST);
   assign led          = pos_to_led(pos);

   // state, position and sweep timer registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= MANUAL;
         pos   <= POS_W'(START_POS);
         cnt   <= '0;
      end else begin
         state <= state_n;
         pos   <= pos_n;
         cnt   <= cnt_n;
      end

   // arbitration: mode press beats manual moves, which beat sweep ticks
   always_comb begin
      state_n = state;
      pos_n   = pos;
      cnt_n   = (!sweep_active || tick) ? '0 : cnt + 1'b1;
      if (press_u) begin
         state_n = (state == MANUAL) ? SWEEP_LEFT : MANUAL;
         cnt_n   = '0;
      end else if (press_l || press_r) begin
         state_n = MANUAL;
         cnt_n   = '0;
         if (press_l && !press_r && pos != POS_MAX) pos_n = pos + 1'b1;
         if (press_r && !press_l && pos != '0)      pos_n = pos - 1'b1;
      end else if (tick) begin
         if (state == SWEEP_LEFT) begin
            state_n = (pos == POS_MAX) ? SWEEP_RIGHT : SWEEP_LEFT;
            pos_n   = (pos == POS_MAX) ? POS_MAX - 1'b1 : pos + 1'b1;
         end else begin
            state_n = (pos == '0) ? SWEEP_LEFT : SWEEP_RIGHT;
            pos_n   = (pos == '0) ? POS_W'(1) : pos - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_led_cursor_ctrl.sv
// tb_led_cursor_ctrl: directed stimulus with a cycle-tagged scoreboard checked by a separate monitor
module tb_led_cursor_ctrl;

   localparam int DB = 4;
   localparam int SD = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btnL = 1'b0;
   logic        btnR = 1'b0;
   logic        btnU = 1'b0;
   logic [15:0] led;
   logic [3:0]  pos;
   logic        sweep_active;

   typedef struct {
      int         at;
      logic [3:0] p;
      logic       sw;
      int         id;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_id = 0;

   led_cursor_ctrl #(.DEBOUNCE_CYCLES(DB), .SWEEP_DIV(SD), .START_POS(7)) dut (
      .clk          (clk),
      .rst          (rst),
      .btnL         (btnL),
      .btnR         (btnR),
      .btnU         (btnU),
      .led          (led),
      .pos          (pos),
      .sweep_active (sweep_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: compare every due scoreboard entry at the falling edge
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].at <= cyc) begin
         m_e = sb.pop_front();
         n_chk++;
         if (pos !== m_e.p || sweep_active !== m_e.sw || led !== (16'd1 << m_e.p)) begin
            n_fail++;
            $display("FAIL chk%0d cyc%0d: got pos=%0d led=%h sw=%b, want pos=%0d led=%h sw=%b",
                     m_e.id, cyc, pos, led, sweep_active, m_e.p, 16'd1 << m_e.p, m_e.sw);
         end
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_at(input int d, input int p, input logic sw);
      n_id++;
      sb.push_back('{cyc + d, 4'(p), sw, n_id});
   endtask

   task automatic set_btn(input int b, input logic v);
      if (b == 0) btnL = v;
      else if (b == 1) btnR = v;
      else btnU = v;
   endtask

   task automatic press(input int b, input int hold, input int rest);
      set_btn(b, 1'b1);
      wait_n(hold);
      set_btn(b, 1'b0);
      wait_n(rest);
   endtask

   initial begin
      wait_n(3);
      rst = 1'b0;
      expect_at(1, 7, 1'b0);
      wait_n(2);
      // long hold: one step at edge 7, no auto-repeat
      expect_at(6, 7, 1'b0);
      expect_at(7, 8, 1'b0);
      expect_at(10, 8, 1'b0);
      press(0, 10, 10);
      expect_at(7, 9, 1'b0);
      press(0, 10, 10);
      // async reset mid-press, button still held afterwards
      btnL = 1'b1;
      wait_n(3);
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (pos !== 4'd7 || led !== 16'h0080 || sweep_active !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst: got pos=%0d led=%h sw=%b, want pos=7 led=0080 sw=0", pos, led, sweep_active);
      end
      wait_n(2);
      rst = 1'b0;
      expect_at(6, 7, 1'b0);
      expect_at(7, 8, 1'b0);
      wait_n(10);
      btnL = 1'b0;
      wait_n(10);
      // short glitch ignored
      expect_at(8, 8, 1'b0);
      expect_at(12, 8, 1'b0);
      press(0, 3, 12);
      // walk right to the lower edge and one beyond
      for (int k = 1; k <= 9; k++) begin
         expect_at(7, (8 - k < 0) ? 0 : 8 - k, 1'b0);
         press(1, 5, 10);
      end
      // simultaneous left and right cancel
      expect_at(7, 0, 1'b0);
      expect_at(12, 0, 1'b0);
      btnL = 1'b1;
      btnR = 1'b1;
      wait_n(12);
      btnL = 1'b0;
      btnR = 1'b0;
      wait_n(10);
      // walk left to the upper edge and one beyond
      for (int k = 1; k <= 16; k++) begin
         expect_at(7, (k > 15) ? 15 : k, 1'b0);
         press(0, 5, 10);
      end
      expect_at(7, 14, 1'b0);
      press(1, 5, 10);
      // sweep from 14: up to 15, bounce down to 14 and 13
      expect_at(6, 14, 1'b0);
      expect_at(7, 14, 1'b1);
      expect_at(14, 14, 1'b1);
      expect_at(15, 15, 1'b1);
      expect_at(22, 15, 1'b1);
      expect_at(23, 14, 1'b1);
      expect_at(30, 14, 1'b1);
      expect_at(31, 13, 1'b1);
      press(2, 5, 27);
      // right press lands on a tick edge: manual move wins, sweep stops
      expect_at(7, 12, 1'b0);
      expect_at(20, 12, 1'b0);
      press(1, 5, 15);
      // re-enter sweep with the timer restarted, then leave via mode press
      expect_at(7, 12, 1'b1);
      expect_at(14, 12, 1'b1);
      expect_at(15, 13, 1'b1);
      press(2, 5, 15);
      expect_at(3, 14, 1'b1);
      expect_at(7, 14, 1'b0);
      expect_at(15, 14, 1'b0);
      press(2, 5, 5);
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d checks still pending, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
